mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencer and arbiter that shares one single-ported, multi-cycle unified memory between the instruction-fetch path and the data-access path of the 16-bit CPU. It accepts level requests from both sides, grants one at a time with data priority, drives the memory port for a fixed latency, and returns read data with a one-cycle done pulse. It also produces the stall signals the pipeline control uses to freeze fetch or memory stages while an access is outstanding.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 4, memory access cycles (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, level, held until if_done or flush
- if_addr  in  ADDR_W  fetch address (PC)
- if_flush  in  1  cancel fetch (taken branch/BR)
- halt  in  1  HLT decoded; blocks new fetch grants
- d_req  in  1  data request (LW/SW), level, held until d_done
- d_wr  in  1  1 = SW, 0 = LW
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- if_rdata  out  DATA_W  fetched instruction, valid when if_done
- if_done  out  1  one-cycle completion pulse, fetch
- if_stall  out  1  if_req & ~if_done
- d_rdata  out  DATA_W  load data, valid when d_done
- d_done  out  1  one-cycle completion pulse, data
- d_stall  out  1  d_req & ~d_done
- mem_en  out  1  memory port active
- mem_wr  out  1  write strobe (qualified by mem_en)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid on last access cycle
- busy  out  1  state ≠ IDLE

## Operation
- FSM: IDLE, BUSY, DONE. Owner register: IF or D. Latency counter 0..MEM_LAT-1.
- IDLE: d_req → owner=D, latch d_addr/d_wr/d_wdata, → BUSY. Else if_req & ~if_flush & ~halt → owner=IF, latch if_addr, wr=0, → BUSY. Else stay.
- BUSY: mem_en=1, mem_addr/mem_wr/mem_wdata from latches; counter increments each cycle. At count MEM_LAT-1: on a read, capture mem_rdata into owner's rdata register; → DONE, counter cleared.
- DONE: owner's done pulses exactly one cycle; mem_en=0; → IDLE unconditionally (no back-to-back grant from DONE).
- Writes: d_done pulses, d_rdata keeps its previous value.
- if_flush: in BUSY with owner IF → abort, mem_en drops next cycle, → IDLE, no if_done, if_rdata unchanged. In DONE with owner IF → if_done suppressed. In IDLE → fetch not granted that cycle. No effect on D-owned accesses.
- halt: blocks only new fetch grants; in-flight fetch completes; data requests still served.
- Inputs latched at grant; later changes to addr/wdata during BUSY ignored.
- mem_addr, mem_wdata, mem_wr are 0 whenever mem_en=0.
- Stalls are combinational from req and done; all other outputs registered.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): state=IDLE, counter=0, all outputs 0 (mem_en, mem_wr, mem_addr, mem_wdata, if_rdata, d_rdata, if_done, d_done, busy).
- Reset mid-access: access abandoned, no done pulse, all to reset values.
- Req sampled in IDLE at edge t → mem_en high t+1..t+MEM_LAT → done high at t+MEM_LAT+1 → IDLE at t+MEM_LAT+2. Total MEM_LAT+1 cycles req-to-done.
- Requester deasserts req at the edge after done; req still high in IDLE at t+MEM_LAT+2 starts a new access.
- Simultaneous if_req and d_req in IDLE: D wins; IF granted at the next IDLE if still requested.
- Throughput: one access per MEM_LAT+2 cycles.

## Structure
- Shared package cpu_pkg: arb_state_t enum (IDLE, BUSY, DONE), arb_owner_t enum (OWN_IF, OWN_D), default MEM_LAT constant.
- Single module; no sub-module. The latency counter is a local $clog2(MEM_LAT)-bit register.

## Test plan
- if_req=1, if_addr=0x0010, mem_rdata=0xA123 on last cycle, MEM_LAT=4 → mem_en high 4 cycles at addr 0x0010, if_done at cycle 5, if_rdata=0xA123, if_stall high cycles 0-4.
- d_req=1, d_wr=1, d_addr=0x0200, d_wdata=0xBEEF → mem_wr=1 4 cycles with 0x0200/0xBEEF, d_done at cycle 5, d_rdata unchanged.
- if_req and d_req (LW 0x0300) asserted same cycle → D served first (d_done cycle 5), IF granted cycle 6, if_done cycle 11.
- Fetch in flight, if_flush pulsed in 2nd BUSY cycle → mem_en low next cycle, no if_done, busy=0 after abort.
- halt=1 with if_req=1 → no grant, mem_en stays 0; concurrent d_req LW 0x0040 still completes.
- rst_n asserted during 3rd BUSY cycle of a SW → all outputs 0 immediately, no d_done after release, next request starts cleanly.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the memory arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which requester currently owns the memory port
//   MEM_LAT_DEF : default memory access latency in cycles
package cpu_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
  typedef enum logic       {OWN_IF, OWN_D}    arb_owner_t;

  localparam int MEM_LAT_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the CPU pipeline, the arbiter and the
// unified memory port.
//   fetch side : if_req/if_addr/if_flush/halt in, if_rdata/if_done/if_stall out
//   data side  : d_req/d_wr/d_addr/d_wdata in, d_rdata/d_done/d_stall out
//   memory     : mem_en/mem_wr/mem_addr/mem_wdata out, mem_rdata in
//   status     : busy
// Modport slave is the arbiter's view; master is the CPU/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req, if_flush, halt;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done, if_stall;

  logic              d_req, d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              d_done, d_stall;

  logic              mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, if_flush, halt,
    input  d_req, d_wr, d_addr, d_wdata,
    input  mem_rdata,
    output if_rdata, if_done, if_stall,
    output d_rdata, d_done, d_stall,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output if_req, if_addr, if_flush, halt,
    output d_req, d_wr, d_addr, d_wdata,
    output mem_rdata,
    input  if_rdata, if_done, if_stall,
    input  d_rdata, d_done, d_stall,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, MEM_LAT-cycle memory between the
// instruction-fetch and data paths. Data requests win ties. An access runs
// IDLE -> BUSY (MEM_LAT cycles, port driven) -> DONE (one-cycle done pulse)
// -> IDLE, so one access completes every MEM_LAT+2 cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_arbiter_if.slave (fetch, data, memory and busy signals)
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              abort;

  // A flush only cancels a fetch; data accesses always run to completion.
  assign abort = (state_q == BUSY) && (owner_q == OWN_IF) && bus.if_flush;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.d_req) begin
          state_d = BUSY;
          owner_d = OWN_D;
          wr_d    = bus.d_wr;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
        end else if (bus.if_req && !bus.if_flush && !bus.halt) begin
          state_d = BUSY;
          owner_d = OWN_IF;
          wr_d    = 1'b0;
          addr_d  = bus.if_addr;
          wdata_d = '0;
        end
      end
      BUSY: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // mem_rdata is only valid on the final access cycle.
          state_d = DONE;
          cnt_d   = '0;
          if (!wr_q) begin
            if (owner_q == OWN_D) d_rdata_d  = bus.mem_rdata;
            else                  if_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Port signals decode straight from flops; the latches are masked so the
  // memory sees zeros whenever the port is idle.
  assign bus.mem_en    = (state_q == BUSY);
  assign bus.mem_wr    = bus.mem_en & wr_q;
  assign bus.mem_addr  = bus.mem_en ? addr_q  : '0;
  assign bus.mem_wdata = bus.mem_en ? wdata_q : '0;
  assign bus.busy      = (state_q != IDLE);

  // A flush arriving in the DONE cycle of a fetch must still swallow the
  // pulse, so if_done is gated by the live flush input.
  assign bus.if_done  = (state_q == DONE) && (owner_q == OWN_IF) && !bus.if_flush;
  assign bus.d_done   = (state_q == DONE) && (owner_q == OWN_D);
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

  assign bus.if_stall = bus.if_req & ~bus.if_done;
  assign bus.d_stall  = bus.d_req  & ~bus.d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test of mem_arbiter. A schedule-based model
// (grant cycle + fixed offsets) predicts every output each cycle; directed
// steps add hand-computed literal checks of latency and data.
module tb_mem_arbiter;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory read data: a per-cycle junk pattern, except one scripted cycle.
  int          rd_cyc = -1;
  logic [15:0] rd_val = '0;
  always @(posedge clk) begin
    #1;
    bus.mem_rdata = (cyc == rd_cyc) ? rd_val : {8'h55, cyc[7:0]};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  bit          m_act = 0;
  int          m_g = 0;
  bit          m_own_d = 0;
  bit          m_wr = 0;
  logic [15:0] m_addr = '0, m_wdata = '0, m_if_rd = '0, m_d_rd = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  <= 0;
      m_if_rd <= '0;
      m_d_rd <= '0;
    end else begin
      automatic int k = cyc - m_g;
      automatic bit abort = m_act && !m_own_d && (k < L) && bus.if_flush;
      automatic bit free  = !m_act || (k == L + 1);
      if (m_act && k == L - 1 && !m_wr && !abort) begin
        if (m_own_d) m_d_rd  <= bus.mem_rdata;
        else         m_if_rd <= bus.mem_rdata;
      end
      if (free && bus.d_req) begin
        m_act <= 1; m_g <= cyc + 1; m_own_d <= 1;
        m_addr <= bus.d_addr; m_wr <= bus.d_wr; m_wdata <= bus.d_wdata;
      end else if (free && bus.if_req && !bus.if_flush && !bus.halt) begin
        m_act <= 1; m_g <= cyc + 1; m_own_d <= 0;
        m_addr <= bus.if_addr; m_wr <= 0; m_wdata <= '0;
      end else if (abort || (m_act && k == L + 1)) begin
        m_act <= 0;
      end
    end
  end

  // Compare every cycle, sampled on the falling edge.
  always @(negedge clk) begin
    automatic int k = cyc - m_g;
    automatic bit en = m_act && (k < L);
    automatic bit dn = m_act && (k == L);
    automatic bit e_ifd = dn && !m_own_d && !bus.if_flush;
    automatic bit e_dd  = dn && m_own_d;
    chk("mem_en",    32'(bus.mem_en),    32'(en));
    chk("mem_wr",    32'(bus.mem_wr),    32'(en && m_wr));
    chk("mem_addr",  32'(bus.mem_addr),  en ? 32'(m_addr)  : 32'h0);
    chk("mem_wdata", 32'(bus.mem_wdata), en ? 32'(m_wdata) : 32'h0);
    chk("busy",      32'(bus.busy),      32'(m_act && k <= L));
    chk("if_done",   32'(bus.if_done),   32'(e_ifd));
    chk("d_done",    32'(bus.d_done),    32'(e_dd));
    chk("if_rdata",  32'(bus.if_rdata),  32'(m_if_rd));
    chk("d_rdata",   32'(bus.d_rdata),   32'(m_d_rd));
    chk("if_stall",  32'(bus.if_stall),  32'(bus.if_req && !e_ifd));
    chk("d_stall",   32'(bus.d_stall),   32'(bus.d_req && !e_dd));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a done pulse and checks its cycle offset from c0.
  task automatic wait_done(input bit is_d, input int exp_lat, input int c0, input string nm);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (is_d ? bus.d_done : bus.if_done) seen = 1;
    end
    chk({nm, "_seen"}, 32'(seen), 32'h1);
    if (seen) chk({nm, "_lat"}, 32'(cyc - c0), 32'(exp_lat));
  endtask

  initial begin
    int c0;
    bit saw;
    bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0; bus.halt = 0;
    bus.d_req = 0; bus.d_wr = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0;

    // Reset state
    tick();
    @(negedge clk);
    chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
    chk("rst_busy",   32'(bus.busy),   32'h0);
    chk("rst_rdata",  32'({bus.if_rdata, bus.d_rdata}), 32'h0);
    tick();
    rst_n = 1;
    tick();

    // 1: fetch 0x0010, data 0xA123, address change after grant ignored
    bus.if_addr = 16'h0010; bus.if_req = 1;
    c0 = cyc; rd_cyc = cyc + 4; rd_val = 16'hA123;
    tick();
    bus.if_addr = 16'hFFFF;
    @(negedge clk);
    chk("t1_addr", 32'(bus.mem_addr), 32'h0010);
    wait_done(0, 5, c0, "t1_done");
    chk("t1_rdata", 32'(bus.if_rdata), 32'hA123);
    tick();
    bus.if_req = 0;
    tick();

    // 2: SW 0x0200 <- 0xBEEF
    bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h0200; bus.d_wdata = 16'hBEEF;
    c0 = cyc;
    tick();
    bus.d_wdata = 16'h0000;
    @(negedge clk);
    chk("t2_wr",    32'(bus.mem_wr),    32'h1);
    chk("t2_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    wait_done(1, 5, c0, "t2_done");
    chk("t2_rdata_kept", 32'(bus.d_rdata), 32'h0);
    tick();
    bus.d_req = 0; bus.d_wr = 0;
    tick();

    // 3: simultaneous LW 0x0300 and fetch: data first
    bus.d_req = 1; bus.d_addr = 16'h0300; bus.if_req = 1; bus.if_addr = 16'h0010;
    c0 = cyc; rd_cyc = cyc + 4; rd_val = 16'h7777;
    wait_done(1, 5, c0, "t3_d");
    chk("t3_drdata", 32'(bus.d_rdata), 32'h7777);
    tick();
    bus.d_req = 0;
    rd_cyc = c0 + 10; rd_val = 16'h1234;
    wait_done(0, 11, c0, "t3_if");
    chk("t3_ifrdata", 32'(bus.if_rdata), 32'h1234);
    tick();
    bus.if_req = 0;
    tick();

    // 4: flush in 2nd BUSY cycle aborts fetch
    bus.if_req = 1; bus.if_addr = 16'h0020;
    tick();
    tick();
    bus.if_flush = 1;
    @(negedge clk);
    chk("t4_en_before", 32'(bus.mem_en), 32'h1);
    tick();
    bus.if_flush = 0; bus.if_req = 0;
    @(negedge clk);
    chk("t4_en_after", 32'(bus.mem_en), 32'h0);
    chk("t4_busy",     32'(bus.busy),   32'h0);
    saw = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.if_done) saw = 1;
    end
    chk("t4_no_done", 32'(saw), 32'h0);
    chk("t4_rdata_kept", 32'(bus.if_rdata), 32'h1234);
    tick();

    // 5: halt blocks fetch, LW 0x0040 still served
    bus.halt = 1; bus.if_req = 1; bus.if_addr = 16'h0030;
    bus.d_req = 1; bus.d_addr = 16'h0040;
    c0 = cyc; rd_cyc = cyc + 4; rd_val = 16'h4040;
    wait_done(1, 5, c0, "t5_d");
    chk("t5_drdata", 32'(bus.d_rdata), 32'h4040);
    tick();
    bus.d_req = 0;
    saw = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mem_en) saw = 1;
    end
    chk("t5_halt_no_en", 32'(saw), 32'h0);
    tick();
    bus.halt = 0;
    c0 = cyc; rd_cyc = cyc + 4; rd_val = 16'h0BAD;
    wait_done(0, 5, c0, "t5_if");
    chk("t5_ifrdata", 32'(bus.if_rdata), 32'h0BAD);
    tick();
    bus.if_req = 0;
    tick();

    // 6: flush during the DONE cycle of a fetch swallows if_done
    bus.if_req = 1; bus.if_addr = 16'h0050;
    c0 = cyc; rd_cyc = cyc + 4; rd_val = 16'h5A5A;
    repeat (5) tick();
    bus.if_flush = 1;
    @(negedge clk);
    chk("t6_done_masked", 32'(bus.if_done), 32'h0);
    chk("t6_busy",        32'(bus.busy),    32'h1);
    tick();
    bus.if_flush = 0; bus.if_req = 0;
    chk("t6_rdata", 32'(bus.if_rdata), 32'h5A5A);
    tick();

    // 7: reset during 3rd BUSY cycle of SW 0x0400
    bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h0400; bus.d_wdata = 16'h1234;
    repeat (3) tick();
    rst_n = 0;
    @(negedge clk);
    chk("t7_en",    32'(bus.mem_en),   32'h0);
    chk("t7_addr",  32'(bus.mem_addr), 32'h0);
    chk("t7_busy",  32'(bus.busy),     32'h0);
    chk("t7_rdata", 32'(bus.if_rdata), 32'h0);
    bus.d_req = 0; bus.d_wr = 0;
    tick();
    tick();
    rst_n = 1;
    saw = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.d_done) saw = 1;
    end
    chk("t7_no_done", 32'(saw), 32'h0);
    tick();
    bus.d_req = 1; bus.d_addr = 16'h0600;
    c0 = cyc; rd_cyc = cyc + 4; rd_val = 16'h6006;
    wait_done(1, 5, c0, "t7_d");
    chk("t7_drdata", 32'(bus.d_rdata), 32'h6006);
    tick();
    bus.d_req = 0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
